mult_pipe_checker: RTL

//  Synthesizable response checker for the two-lane pipelined multiplier `main` (go_T, l0/r0, l1/r1 -> out0/out1).

---
 rtl/mult_chk_pkg.sv | 31 +++
 rtl/mult_chk_delay.sv | 50 +++++
 rtl/mult_pipe_checker.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mult_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mult_chk_pkg
// Brief   : Shared types, default parameters and saturating add for the
//           two-lane multiplier response checker.
// Rev     : 1.0  initial release
// ============================================================================
package mult_chk_pkg;

    localparam int C_DEF_WIDTH    = 32;
    localparam int C_DEF_OP1_OFS  = 2;
    localparam int C_DEF_OUT0_LAT = 2;
    localparam int C_DEF_OUT1_LAT = 4;
    localparam int C_DEF_CNT_W    = 16;

    typedef struct packed {
        logic                   vld;
        logic [C_DEF_WIDTH-1:0] exp;
    } chk_entry_t;

    // Counters up to 63 bits are carried at 64 bits so the sum never wraps.
    function automatic logic [63:0] sat_add(input logic [63:0] cnt,
                                            input logic [1:0]  inc,
                                            input logic [63:0] max_val);
        logic [63:0] sum;
        sum = cnt + {62'd0, inc};
        return (sum > max_val) ? max_val : sum;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_chk_delay.sv
`default_nettype none
// ============================================================================
// Module  : mult_chk_delay
// Brief   : Valid+data shift register of DEPTH stages, synchronous clear.
// Rev     : 1.0  initial release
// ============================================================================
module mult_chk_delay #(
    parameter int DEPTH = 1,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_vld,
    input  logic [W-1:0] in_data,
    output logic         out_vld,
    output logic [W-1:0] out_data,
    output logic         any_vld
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign out_vld  = in_vld;
            assign out_data = in_data;
            assign any_vld  = 1'b0;
        end else begin : g_shift
            logic [DEPTH-1:0] r_vld;
            logic [W-1:0]     r_data [DEPTH];

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_vld <= '0;
                    for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
                end else begin
                    r_vld[0]  <= in_vld;
                    r_data[0] <= in_data;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_vld[i]  <= r_vld[i-1];
                        r_data[i] <= r_data[i-1];
                    end
                end
            end

            assign out_vld  = r_vld[DEPTH-1];
            assign out_data = r_data[DEPTH-1];
            assign any_vld  = |r_vld;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/mult_pipe_checker.sv
`default_nettype none
// ============================================================================
// Module  : mult_pipe_checker
// Brief   : Response checker for a two-lane pipelined multiplier; optional
//           first-mismatch capture enabled by MULT_CHK_FIRST_ERR_EN.
// Rev     : 1.0  initial release
// ============================================================================
module mult_pipe_checker
    import mult_chk_pkg::*;
#(
    parameter int WIDTH    = C_DEF_WIDTH,
    parameter int OP1_OFS  = C_DEF_OP1_OFS,
    parameter int OUT0_LAT = C_DEF_OUT0_LAT,
    parameter int OUT1_LAT = C_DEF_OUT1_LAT,
    parameter int CNT_W    = C_DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go_T,
    input  logic [WIDTH-1:0] l0,
    input  logic [WIDTH-1:0] r0,
    input  logic [WIDTH-1:0] l1,
    input  logic [WIDTH-1:0] r1,
    input  logic [WIDTH-1:0] out0,
    input  logic [WIDTH-1:0] out1,
    output logic             chk0_vld,
    output logic             chk0_ok,
    output logic             chk1_vld,
    output logic             chk1_ok,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             idle
`ifdef MULT_CHK_FIRST_ERR_EN
    ,
    output logic             first_err_vld,
    output logic             first_err_lane,
    output logic [WIDTH-1:0] first_err_got,
    output logic [WIDTH-1:0] first_err_exp,
    output logic [CNT_W-1:0] first_err_cyc
`endif
);

    localparam int               C_L1_DEPTH = OUT1_LAT - OP1_OFS;
    localparam logic [CNT_W-1:0] C_CNT_MAX  = '1;

    generate
        if (OUT0_LAT < 1 || OUT1_LAT <= OP1_OFS) begin : g_bad_params
            $error("mult_pipe_checker: requires OUT0_LAT >= 1 and OUT1_LAT > OP1_OFS");
        end
    endgenerate

    logic             w_go_vld, w_go_tag, w_go_any, w_start1;
    logic             w_vld0, w_vld1, w_any0, w_any1;
    logic             w_ok0, w_ok1;
    logic [WIDTH-1:0] w_prod0, w_prod1, w_exp0, w_exp1;
    logic [1:0]       w_inc_pass, w_inc_err;

    assign w_prod0 = l0 * r0;
    assign w_prod1 = w_start1 ? l1 * r1 : '0;

    // The trigger rides in both the valid and data bit of the go chain.
    mult_chk_delay #(.DEPTH(OP1_OFS), .W(1)) u_go_chain (
        .clk(clk), .reset(reset), .in_vld(go_T), .in_data(go_T),
        .out_vld(w_go_vld), .out_data(w_go_tag), .any_vld(w_go_any)
    );
    assign w_start1 = w_go_vld & w_go_tag;

    mult_chk_delay #(.DEPTH(OUT0_LAT), .W(WIDTH)) u_lane0 (
        .clk(clk), .reset(reset), .in_vld(go_T), .in_data(w_prod0),
        .out_vld(w_vld0), .out_data(w_exp0), .any_vld(w_any0)
    );

    mult_chk_delay #(.DEPTH(C_L1_DEPTH), .W(WIDTH)) u_lane1 (
        .clk(clk), .reset(reset), .in_vld(w_start1), .in_data(w_prod1),
        .out_vld(w_vld1), .out_data(w_exp1), .any_vld(w_any1)
    );

    // An unknown bit makes the equality unknown, which falls to mismatch.
    always_comb begin
        w_ok0 = 1'b0;
        w_ok1 = 1'b0;
        if (out0 == w_exp0) w_ok0 = 1'b1;
        if (out1 == w_exp1) w_ok1 = 1'b1;
    end

    assign w_inc_pass = {1'b0, w_vld0 &  w_ok0} + {1'b0, w_vld1 &  w_ok1};
    assign w_inc_err  = {1'b0, w_vld0 & ~w_ok0} + {1'b0, w_vld1 & ~w_ok1};

    always_ff @(posedge clk) begin
        if (reset) begin
            chk0_vld <= 1'b0;
            chk0_ok  <= 1'b0;
            chk1_vld <= 1'b0;
            chk1_ok  <= 1'b0;
            pass_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            chk0_vld <= w_vld0;
            chk0_ok  <= w_vld0 & w_ok0;
            chk1_vld <= w_vld1;
            chk1_ok  <= w_vld1 & w_ok1;
            pass_cnt <= CNT_W'(sat_add(64'(pass_cnt), w_inc_pass, 64'(C_CNT_MAX)));
            err_cnt  <= CNT_W'(sat_add(64'(err_cnt),  w_inc_err,  64'(C_CNT_MAX)));
        end
    end

    assign idle = ~(w_go_any | w_any0 | w_any1);

`ifdef MULT_CHK_FIRST_ERR_EN
    logic [CNT_W-1:0] r_stamp;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stamp        <= '0;
            first_err_vld  <= 1'b0;
            first_err_lane <= 1'b0;
            first_err_got  <= '0;
            first_err_exp  <= '0;
            first_err_cyc  <= '0;
        end else begin
            r_stamp <= r_stamp + CNT_W'(1);
            if (!first_err_vld) begin
                if (w_vld0 && !w_ok0) begin
                    first_err_vld  <= 1'b1;
                    first_err_lane <= 1'b0;
                    first_err_got  <= out0;
                    first_err_exp  <= w_exp0;
                    first_err_cyc  <= r_stamp;
                end else if (w_vld1 && !w_ok1) begin
                    first_err_vld  <= 1'b1;
                    first_err_lane <= 1'b1;
                    first_err_got  <= out1;
                    first_err_exp  <= w_exp1;
                    first_err_cyc  <= r_stamp;
                end
            end
        end
    end
`endif

endmodule
`default_nettype wire
